// File: rtl/uart_pkg.sv
// Shared UART types: parity modes, receiver FSM states and the received-word payload.
package uart_pkg;

  localparam int unsigned UART_MIN_DATA_BITS = 5;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP1,
    RX_STOP2,
    RX_BRK_WAIT
  } rx_ovs_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       parity_error;
    logic       frame_error;
    logic       brk;
  } rx_word_t;

  // Register encoding 11 is an alias for "no parity".
  function automatic parity_mode_e decode_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every i_div clocks, restarted by i_reload.
module uart_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_reload,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;

  // Divider latch on reload (0 treated as 1), free-running count otherwise.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      div_q  <= DIV_W'(1);
      cnt_q  <= '0;
      o_tick <= 1'b0;
    end else if (i_reload) begin
      div_q  <= (i_div == '0) ? DIV_W'(1) : i_div;
      cnt_q  <= '0;
      o_tick <= 1'b0;
    end else if (cnt_q == div_q - DIV_W'(1)) begin
      cnt_q  <= '0;
      o_tick <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + DIV_W'(1);
      o_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with majority voting, runtime framing, break detection
// and a valid/ready output with overrun reporting.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int unsigned OVS         = 16,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_baud_div,
  input  logic             i_rx,
  input  logic [1:0]       i_data_bits,
  input  logic [1:0]       i_parity_mode,
  input  logic             i_stop_bits,
  input  logic             i_msb_first,
  output logic [7:0]       o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_parity_error,
  output logic             o_frame_error,
  output logic             o_break,
  output logic             o_overrun,
  output logic             o_busy
);

  localparam int unsigned CNT_W = $clog2(OVS);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVS / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs, rxs_d;
  logic                   tick;
  logic [CNT_W-1:0]       ovs_cnt_q;
  logic [1:0]             win_q;
  logic                   mid_c, maj_c, fall_c;

  rx_ovs_state_e state_q, state_d;
  logic [2:0]    nbits_m1_q;
  parity_mode_e  par_q;
  logic          stop2_q, msb_q;
  logic [7:0]    data_q;
  logic [2:0]    bit_idx_q;
  logic          par_acc_q, zero_q, perr_q, ferr_q;
  logic          last_bit_c;
  logic [2:0]    pos_c;

  logic     start_c, capture_c, par_chk_c, stop_c, brk_c, done_c;
  rx_word_t word_c;

  assign rxs    = sync_q[SYNC_STAGES-1];
  assign fall_c = rxs_d & ~rxs;

  // Line synchroniser plus one-cycle history for edge detection; idle level is high.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      sync_q <= '1;
      rxs_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
      rxs_d  <= rxs;
    end
  end

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .i_clk    (i_clk),
    .i_nrst   (i_nrst),
    .i_reload (start_c),
    .i_div    (i_baud_div),
    .o_tick   (tick)
  );

  // Per-bit oversample counter and sample window, both aligned to the start edge.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      ovs_cnt_q <= '0;
      win_q     <= '1;
    end else if (start_c) begin
      ovs_cnt_q <= '0;
    end else if (tick) begin
      ovs_cnt_q <= (ovs_cnt_q == CNT_LAST) ? '0 : ovs_cnt_q + CNT_W'(1);
      win_q     <= {win_q[0], rxs};
    end
  end

  assign mid_c = tick && (ovs_cnt_q == CNT_MID);
  assign maj_c = (win_q[1] & win_q[0]) | (win_q[1] & rxs) | (win_q[0] & rxs);

  assign last_bit_c = (bit_idx_q == nbits_m1_q);
  assign pos_c      = msb_q ? (nbits_m1_q - bit_idx_q) : bit_idx_q;

  // State register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state_q <= RX_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; a low enable aborts any frame in progress.
  always_comb begin
    state_d = state_q;
    if (!i_en) begin
      state_d = RX_IDLE;
    end else begin
      case (state_q)
        RX_IDLE:     if (fall_c) state_d = RX_START;
        RX_START:    if (mid_c) state_d = maj_c ? RX_IDLE : RX_DATA;
        RX_DATA:     if (mid_c && last_bit_c) state_d = (par_q != PAR_NONE) ? RX_PARITY : RX_STOP1;
        RX_PARITY:   if (mid_c) state_d = RX_STOP1;
        RX_STOP1:    if (mid_c) state_d = brk_c ? RX_BRK_WAIT : (stop2_q ? RX_STOP2 : RX_IDLE);
        RX_STOP2:    if (mid_c) state_d = RX_IDLE;
        RX_BRK_WAIT: if (rxs) state_d = RX_IDLE;
        default:     state_d = RX_IDLE;
      endcase
    end
  end

  // Per-state strobes driving the datapath and the output register.
  always_comb begin
    start_c   = 1'b0;
    capture_c = 1'b0;
    par_chk_c = 1'b0;
    stop_c    = 1'b0;
    brk_c     = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      RX_IDLE:   start_c   = i_en & fall_c;
      RX_DATA:   capture_c = mid_c;
      RX_PARITY: par_chk_c = mid_c;
      RX_STOP1: begin
        stop_c = mid_c;
        brk_c  = mid_c & ~maj_c & zero_q;
        done_c = i_en & mid_c & (brk_c | ~stop2_q);
      end
      RX_STOP2: begin
        stop_c = mid_c;
        done_c = i_en & mid_c;
      end
      default: ;
    endcase
  end

  // Frame configuration snapshot, taken only when a start edge is accepted.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      nbits_m1_q <= 3'd7;
      par_q      <= PAR_NONE;
      stop2_q    <= 1'b0;
      msb_q      <= 1'b0;
    end else if (start_c) begin
      nbits_m1_q <= 3'(UART_MIN_DATA_BITS - 1) + 3'(i_data_bits);
      par_q      <= decode_parity(i_parity_mode);
      stop2_q    <= i_stop_bits;
      msb_q      <= i_msb_first;
    end
  end

  // Data shift-in, running parity, all-zero tracking for break, and error flags.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      data_q    <= '0;
      bit_idx_q <= '0;
      par_acc_q <= 1'b0;
      zero_q    <= 1'b1;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else if (start_c) begin
      data_q    <= '0;
      bit_idx_q <= '0;
      par_acc_q <= 1'b0;
      zero_q    <= 1'b1;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      if (capture_c) begin
        data_q[pos_c] <= maj_c;
        bit_idx_q     <= bit_idx_q + 3'd1;
        par_acc_q     <= par_acc_q ^ maj_c;
        zero_q        <= zero_q & ~maj_c;
      end
      if (par_chk_c) begin
        perr_q <= par_acc_q ^ maj_c ^ (par_q == PAR_ODD);
        zero_q <= zero_q & ~maj_c;
      end
      if (stop_c && !maj_c) ferr_q <= 1'b1;
    end
  end

  // The current stop sample is folded in directly since ferr_q updates a cycle late.
  always_comb begin
    word_c.data         = data_q;
    word_c.parity_error = perr_q;
    word_c.frame_error  = ferr_q | (stop_c & ~maj_c);
    word_c.brk          = brk_c;
  end

  // Output holding register with valid/ready handshake and overrun pulse.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_data         <= '0;
      o_valid        <= 1'b0;
      o_parity_error <= 1'b0;
      o_frame_error  <= 1'b0;
      o_break        <= 1'b0;
      o_overrun      <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      o_busy    <= (state_d != RX_IDLE);
      if (done_c) begin
        if (!o_valid || i_ready) begin
          o_data         <= word_c.data;
          o_parity_error <= word_c.parity_error;
          o_frame_error  <= word_c.frame_error;
          o_break        <= word_c.brk;
          o_valid        <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: OVS=16, divider 4 (64 clocks per bit).
module tb_uart_rx_ovs;

  localparam int BIT = 64;

  logic        i_clk = 1'b0;
  logic        i_nrst, i_en, i_rx, i_ready, i_stop_bits, i_msb_first;
  logic [1:0]  i_data_bits, i_parity_mode;
  logic [15:0] i_baud_div;
  logic [7:0]  o_data;
  logic        o_valid, o_parity_error, o_frame_error, o_break, o_overrun, o_busy;

  int n_assert = 0;
  int n_fail   = 0;

  int         cap_cnt = 0;
  int         ovr_cnt = 0;
  logic [7:0] cap_data = '0;
  logic       cap_perr = 1'b0, cap_ferr = 1'b0, cap_brk = 1'b0;

  uart_rx_ovs #(.OVS(16), .DIV_W(16), .SYNC_STAGES(2)) dut (
    .i_clk          (i_clk),
    .i_nrst         (i_nrst),
    .i_en           (i_en),
    .i_baud_div     (i_baud_div),
    .i_rx           (i_rx),
    .i_data_bits    (i_data_bits),
    .i_parity_mode  (i_parity_mode),
    .i_stop_bits    (i_stop_bits),
    .i_msb_first    (i_msb_first),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_parity_error (o_parity_error),
    .o_frame_error  (o_frame_error),
    .o_break        (o_break),
    .o_overrun      (o_overrun),
    .o_busy         (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Record every cycle the output word is presented, and every overrun cycle.
  always @(negedge i_clk) begin
    if (o_valid) begin
      cap_cnt  <= cap_cnt + 1;
      cap_data <= o_data;
      cap_perr <= o_parity_error;
      cap_ferr <= o_frame_error;
      cap_brk  <= o_break;
    end
    if (o_overrun) ovr_cnt <= ovr_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    for (int c = 0; c < BIT; c++) begin
      @(negedge i_clk);
      i_rx = (glitch && c >= 32 && c < 36) ? ~b : b;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input logic [1:0] pm,
                            input bit bad_par, input bit two_stop, input bit msb, input int glitch);
    logic b, par;
    i_data_bits   = 2'(n - 5);
    i_parity_mode = pm;
    i_stop_bits   = two_stop;
    i_msb_first   = msb;
    par = 1'b0;
    send_bit(1'b0, 1'b0);
    for (int k = 0; k < n; k++) begin
      b = msb ? d[n-1-k] : d[k];
      par ^= b;
      send_bit(b, k == glitch);
    end
    if (pm == 2'b01 || pm == 2'b10) send_bit(par ^ (pm == 2'b10) ^ bad_par, 1'b0);
    send_bit(1'b1, 1'b0);
    if (two_stop) send_bit(1'b1, 1'b0);
  endtask

  task automatic measure_lat(output int t);
    @(negedge i_clk);
    t = 0;
    while (t < 2000) begin
      @(negedge i_clk);
      t++;
      if (o_valid) break;
    end
  endtask

  initial begin
    int lat, c0, o0;
    i_nrst = 1'b0; i_en = 1'b1; i_rx = 1'b1; i_ready = 1'b1;
    i_baud_div = 16'd4; i_data_bits = 2'd3; i_parity_mode = 2'd0;
    i_stop_bits = 1'b0; i_msb_first = 1'b0;

    // Reset state
    repeat (3) @(negedge i_clk);
    check("rst_data", 32'(o_data), 32'h0);
    check("rst_ctrl", 32'({o_valid, o_busy, o_parity_error, o_frame_error, o_break, o_overrun}), 32'h0);
    i_nrst = 1'b1;
    repeat (10) @(negedge i_clk);
    check("idle_busy", 32'(o_busy), 32'h0);

    // 8N1 LSB-first 0xA5, ready held high
    c0 = cap_cnt;
    fork
      send_frame(8'hA5, 8, 2'b00, 1'b0, 1'b0, 1'b0, -1);
      measure_lat(lat);
    join
    check("a5_data", 32'(cap_data), 32'hA5);
    check("a5_flags", 32'({cap_perr, cap_ferr, cap_brk}), 32'h0);
    check("a5_valid_cycles", 32'(cap_cnt - c0), 32'd1);
    check("a5_latency_range", 32'(lat >= 606 && lat <= 626), 32'd1);
    check("a5_idle_after", 32'({o_valid, o_busy}), 32'h0);

    // 7E2 MSB-first 0x5A with inverted parity bit
    send_frame(8'h5A, 7, 2'b01, 1'b1, 1'b1, 1'b1, -1);
    check("7e2_data", 32'(cap_data), 32'h5A);
    check("7e2_perr", 32'(cap_perr), 32'h1);
    check("7e2_ferr", 32'(cap_ferr), 32'h0);

    // One-tick low glitch while idle is a false start
    c0 = cap_cnt;
    @(negedge i_clk); i_rx = 1'b0;
    repeat (4) @(negedge i_clk); i_rx = 1'b1;
    repeat (4) @(negedge i_clk);
    check("glitch_busy_start", 32'(o_busy), 32'h1);
    repeat (2 * BIT) @(negedge i_clk);
    check("glitch_busy_idle", 32'(o_busy), 32'h0);
    check("glitch_no_valid", 32'(cap_cnt - c0), 32'd0);

    // One-tick glitch inside data bit 3 is outvoted
    send_frame(8'h96, 8, 2'b00, 1'b0, 1'b0, 1'b0, 3);
    check("bitglitch_data", 32'(cap_data), 32'h96);

    // Break: line low for 20 bit times
    c0 = cap_cnt;
    @(negedge i_clk); i_rx = 1'b0;
    repeat (20 * BIT) @(negedge i_clk);
    check("brk_valid_cycles", 32'(cap_cnt - c0), 32'd1);
    check("brk_flag", 32'(cap_brk), 32'h1);
    check("brk_ferr", 32'(cap_ferr), 32'h1);
    check("brk_data", 32'(cap_data), 32'h0);
    check("brk_wait_busy", 32'(o_busy), 32'h1);
    i_rx = 1'b1;
    repeat (2 * BIT) @(negedge i_clk);
    check("brk_release_idle", 32'(o_busy), 32'h0);
    check("brk_no_new_frame", 32'(cap_cnt - c0), 32'd1);
    send_frame(8'h3C, 8, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    check("post_brk_data", 32'(cap_data), 32'h3C);
    check("post_brk_flags", 32'({cap_perr, cap_ferr, cap_brk}), 32'h0);

    // Back-to-back frames with ready low: first held, second dropped
    i_ready = 1'b0;
    o0 = ovr_cnt;
    fork
      send_frame(8'h11, 8, 2'b00, 1'b0, 1'b0, 1'b0, -1);
      measure_lat(lat);
    join
    send_frame(8'h22, 8, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    check("ovr_held_data", 32'(o_data), 32'h11);
    check("ovr_held_valid", 32'(o_valid), 32'h1);
    check("ovr_pulse_cycles", 32'(ovr_cnt - o0), 32'd1);

    // Ready raised exactly in the completion cycle of the third frame
    fork
      send_frame(8'h33, 8, 2'b00, 1'b0, 1'b0, 1'b0, -1);
      begin
        @(negedge i_clk);
        repeat (lat - 1) @(negedge i_clk);
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
      end
    join
    check("same_cycle_data", 32'(o_data), 32'h33);
    check("same_cycle_valid", 32'(o_valid), 32'h1);
    check("same_cycle_no_ovr", 32'(ovr_cnt - o0), 32'd1);

    // Enable dropped mid-data: frame discarded, held word untouched
    o0 = ovr_cnt;
    fork
      send_frame(8'hF0, 8, 2'b00, 1'b0, 1'b0, 1'b0, -1);
      begin
        repeat (100) @(negedge i_clk);
        check("en_busy_before", 32'(o_busy), 32'h1);
        repeat (3 * BIT - 100) @(negedge i_clk);
        i_en = 1'b0;
        repeat (3) @(negedge i_clk);
        check("en_drop_idle", 32'(o_busy), 32'h0);
      end
    join
    i_en = 1'b1;
    repeat (BIT) @(negedge i_clk);
    check("en_drop_data_kept", 32'(o_data), 32'h33);
    check("en_drop_no_ovr", 32'(ovr_cnt - o0), 32'd0);

    // Asynchronous reset mid-frame
    fork
      send_frame(8'hF0, 8, 2'b00, 1'b0, 1'b0, 1'b0, -1);
      begin
        repeat (3 * BIT + 10) @(negedge i_clk);
        #3 i_nrst = 1'b0;
        #1;
        check("arst_outputs", 32'({o_data, o_valid, o_busy, o_overrun}), 32'h0);
        repeat (3 * BIT) @(negedge i_clk);
        i_nrst = 1'b1;
      end
    join
    c0 = cap_cnt;
    repeat (2 * BIT) @(negedge i_clk);
    check("post_rst_outputs", 32'({o_data, o_valid, o_busy, o_parity_error, o_frame_error, o_break, o_overrun}), 32'h0);
    check("post_rst_no_valid", 32'(cap_cnt - c0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ovs.md
# uart_rx_ovs

Parametrised, oversampling UART receiver. It replaces the single-sample receiver with these additions:
- majority-vote bit sampling and false-start rejection;
- runtime-selectable 5–8 data bits, parity mode and stop bits;
- break detection;
- a valid/ready output handshake with overrun reporting.

It sits between the pad-side `i_rx` line and the RX FIFO / register block of the UART top.

## Interface
Parameters:
- `OVS`, default 16: oversampling ticks per bit. Must be even and ≥ 8.
- `DIV_W`, default 16: width of the baud divider.
- `SYNC_STAGES`, default 2: flops in the `i_rx` synchroniser, ≥ 2.

Ports:
- `i_clk`  in  1: clock.
- `i_nrst`  in  1: reset, asynchronous, active-low.
- `i_en`  in  1: receiver enable. Low forces IDLE.
- `i_baud_div`  in  DIV_W: `i_clk` cycles per oversample tick. 0 is treated as 1.
- `i_rx`  in  1: serial line, asynchronous, idle high.
- `i_data_bits`  in  2: number of data bits = 5 + value.
- `i_parity_mode`  in  2: 00 none, 01 even, 10 odd, 11 none.
- `i_stop_bits`  in  1: 0 = one stop bit, 1 = two stop bits.
- `i_msb_first`  in  1: bit order on the wire.
- `o_data`  out  8: received word, right-justified, unused upper bits 0.
- `o_valid`  out  1: `o_data` and the error flags are valid.
- `i_ready`  in  1: consumer accepts the word.
- `o_parity_error`  out  1: parity mismatch. Qualified by `o_valid`.
- `o_frame_error`  out  1: a stop bit sampled 0. Qualified by `o_valid`.
- `o_break`  out  1: break frame. Qualified by `o_valid`.
- `o_overrun`  out  1: one-cycle pulse when a completed frame is dropped.
- `o_busy`  out  1: FSM not in IDLE.

## Operation
- `i_rx` passes through `SYNC_STAGES` flops. All logic uses the synchronised value `rxs`.
- Tick generator: counts `i_clk` cycles up to the latched divider value and emits a one-cycle `tick`.
  - The divider is reloaded on each start detection.
  - `i_baud_div`, `i_data_bits`, `i_parity_mode`, `i_stop_bits` and `i_msb_first` are latched in IDLE on start detection. Changes mid-frame have no effect.
- Each tick shifts `rxs` into a 3-bit sample window.
- Per-bit tick counter runs 0..OVS-1. At count OVS/2 the bit value is the majority of the window (counts OVS/2-2 .. OVS/2).
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT.
  - IDLE: a falling edge on `rxs` with `i_en`=1 goes to START. The tick counter and divider are cleared.
  - START: at mid-bit, a majority of 1 is a false start and returns to IDLE with no output. A majority of 0 goes to DATA.
  - DATA: one bit is captured per OVS ticks. After N = 5 + `i_data_bits` bits, go to PARITY if parity is enabled, else STOP1.
  - PARITY: the sampled bit is compared against even/odd parity over the N data bits. Then go to STOP1.
  - STOP1: a sample of 0 sets the frame error. Then go to STOP2 if two stop bits are selected, else the frame completes.
  - STOP2: a sample of 0 sets the frame error. The frame then completes.
  - Break: data, parity and the STOP1 sample are all 0. The frame completes immediately at STOP1 mid with `o_break`=1 and `o_frame_error`=1, then goes to BRK_WAIT.
  - BRK_WAIT: stays until `rxs`=1, then goes to IDLE. No start detection happens in this state.
  - After normal completion the FSM returns to IDLE at the last stop-bit mid. The next falling edge is accepted from the following cycle.
- Bit placement:
  - LSB-first: the k-th received bit goes to `o_data[k]`.
  - MSB-first: the k-th received bit goes to `o_data[N-1-k]`.
  - The bit index is 3 bits wide; no wraparound is possible for N ≤ 8.
- Output register (word, flags, `o_valid`):
  - On completion with `o_valid`=0, or with `o_valid`=1 and `i_ready`=1 in the same cycle: load the new word and flags, `o_valid`=1.
  - On completion with `o_valid`=1 and `i_ready`=0: drop the new frame, keep the old word, pulse `o_overrun`.
  - `o_valid` & `i_ready` with no completion: clear `o_valid` next cycle.
- `i_en` falling mid-frame: the FSM goes to IDLE next cycle and the partial frame is discarded. The output register and handshake continue working.

## Timing
- Reset values: `o_data`=0, `o_valid`=0, all flags 0, `o_overrun`=0, `o_busy`=0, FSM IDLE.
- Start detection: the falling edge is seen `SYNC_STAGES` cycles after the `i_rx` edge.
- `o_valid` rises the cycle after the tick at the last stop-bit mid, or the STOP1 mid for a break.
- End-to-end: about (1 + N + P + S − 0.5)·OVS·div + `SYNC_STAGES` + 1 cycles, where P is 1 if parity is enabled and S is the number of stop bits.
- `o_busy` rises the cycle after start detection.
- `o_overrun` is exactly 1 cycle wide.

## Structure
- `uart_pkg` additions:
  - `parity_mode_e` (NONE, EVEN, ODD);
  - `rx_ovs_state_e`;
  - `UART_MIN_DATA_BITS` = 5.
- One sub-module, `uart_baud_tick`: divider/tick generator with a reload input. It is reusable by the future TX successor.

## Test plan
- 115200-style config (`i_baud_div`=4, `OVS`=16), 8N1, LSB-first, frame 0xA5 with `i_ready` held 1 → `o_data`=0xA5, `o_valid` for 1 cycle, no flags.
- 7E2, MSB-first, 0x5A with wrong parity bit → `o_data`=0x5A, `o_parity_error`=1, `o_frame_error`=0.
- 8N1 with a 1-tick low glitch on `i_rx` in IDLE → no `o_valid`, FSM returns to IDLE. A 1-tick glitch inside a data bit is outvoted and the word is still correct.
- Line held low for 20 bit times → `o_break`=1, `o_frame_error`=1, `o_data`=0. No new frame until the line goes high. A frame after release is received correctly.
- Two back-to-back frames 0x11, 0x22 with `i_ready`=0 → 0x11 held, `o_overrun` pulses once. Then set `i_ready`=1 on the same cycle as a third frame 0x33 completes → 0x33 loaded, no overrun.
- `i_en` dropped mid-data, then an async reset asserted mid-frame → FSM returns to IDLE with no `o_valid`. After reset all outputs are 0.
